// File: rtl/axi_wr_burst_master.sv
// -----------------------------------------------------------------------------
// axi_wr_burst_master
//
// Single-outstanding AXI4 write-burst master. Accepts one (address, length)
// command at a time, rejects bursts that would cross a 4 KB page, issues the
// AW handshake, passes write beats straight through from a valid/ready source
// to the W channel, collects the B response and reports status with a
// one-cycle done pulse.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_addr, cmd_len             burst start byte address, beats - 1
//   in_valid/in_ready/in_data     write-data source (consumed only in W)
//   axi_aw*                       AXI4 write-address channel (INCR, full width)
//   axi_w*                        AXI4 write-data channel (all strobes set)
//   axi_b*                        AXI4 write-response channel
//   done, err                     completion pulse and status
//                                 (00 OK, 01 4KB reject, 10 SLVERR, 11 DECERR)
//   burst_cnt                     bursts completed with OK status (wraps)
// -----------------------------------------------------------------------------
module axi_wr_burst_master #(
  parameter int ID_W     = 4,
  parameter int AWID_VAL = 5,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  // write-data source
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  // AXI write address
  output logic [ID_W-1:0]       axi_awid,
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic [LEN_W-1:0]      axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  // AXI write data
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  output logic                  axi_wlast,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  // AXI write response
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  // status
  output logic                  done,
  output logic [1:0]            err,
  output logic [15:0]           burst_cnt
);

  localparam int BYTES  = DATA_W / 8;
  localparam int SIZE_L = $clog2(BYTES);
  // Wide enough that page offset + burst bytes never overflows; 14 bits for
  // the default 8-bit length and 4-byte beats.
  localparam int CHK_W  = (LEN_W + 1 + SIZE_L > 13) ? (LEN_W + 2 + SIZE_L) : 14;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_4KB   = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_AW,
    S_W,
    S_B,
    S_RPT
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
  logic [LEN_W-1:0]   awlen_q, awlen_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [1:0]         err_q, err_d;
  logic [15:0]        burst_cnt_q, burst_cnt_d;

  logic [CHK_W-1:0]   span;
  logic               w_hs;

  // End of the burst measured from the start of its 4 KB page, using the raw
  // (possibly unaligned) start address.
  assign span = CHK_W'(awaddr_q[11:0]) + ((CHK_W'(awlen_q) + CHK_W'(1)) << SIZE_L);
  assign w_hs = (state_q == S_W) && in_valid && axi_wready;

  // NOTE: every variable is given its hold value before the case statement, so
  // no path through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    beat_d      = beat_q;
    err_d       = err_q;
    burst_cnt_d = burst_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          awaddr_d = cmd_addr;
          awlen_d  = cmd_len;
          beat_d   = '0;
          state_d  = S_CHK;
        end
      end
      S_CHK: begin
        if (span > CHK_W'(4096)) begin
          err_d   = ERR_4KB;
          state_d = S_RPT;
        end else begin
          state_d = S_AW;
        end
      end
      S_AW: begin
        if (axi_awready) state_d = S_W;
      end
      S_W: begin
        if (w_hs) begin
          beat_d = beat_q + LEN_W'(1);
          if (beat_q == awlen_q) state_d = S_B;
        end
      end
      S_B: begin
        if (axi_bvalid) begin
          // OKAY and EXOKAY both report success; SLVERR/DECERR map one-to-one.
          err_d   = axi_bresp[1] ? axi_bresp : ERR_OK;
          state_d = S_RPT;
        end
      end
      S_RPT: begin
        if (err_q == ERR_OK) burst_cnt_d = burst_cnt_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      beat_q      <= '0;
      err_q       <= ERR_OK;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Handshake outputs decode directly from the state register, so an
  // asynchronous reset drops them in the same cycle.
  assign cmd_ready   = (state_q == S_IDLE);

  assign axi_awid    = ID_W'(AWID_VAL);
  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awsize  = 3'(SIZE_L);
  assign axi_awburst = 2'b01;
  assign axi_awvalid = (state_q == S_AW);

  // W channel is a pure pass-through between the data source and the slave.
  assign axi_wdata   = in_data;
  assign axi_wstrb   = '1;
  assign axi_wvalid  = (state_q == S_W) && in_valid;
  assign in_ready    = (state_q == S_W) && axi_wready;
  assign axi_wlast   = (state_q == S_W) && (beat_q == awlen_q);

  assign axi_bready  = (state_q == S_B);

  assign done        = (state_q == S_RPT);
  assign err         = err_q;
  assign burst_cnt   = burst_cnt_q;

endmodule
